// File: rtl/core_seq_ctrl.sv
// Instruction sequencer for the attention core: kernel preload, Q streaming,
// then output-FIFO drain into psum memory. Host Q/K writes pass through in IDLE only.
module core_seq_ctrl #(
    parameter int col    = 8,
    parameter int addr_w = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] n_q_m1,
    input  logic              host_wr_q,
    input  logic              host_wr_k,
    input  logic [addr_w-1:0] host_addr,
    input  logic              fifo_valid,
    output logic [16:0]       inst,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KLOAD,
        S_KFLUSH,
        S_EXEC,
        S_EFLUSH,
        S_DRAIN
    } state_t;

    localparam logic [addr_w-1:0] K_LAST = addr_w'(col - 1);

    state_t            r_state;
    logic [addr_w-1:0] r_k_cnt;
    logic [addr_w-1:0] r_q_cnt;
    logic [addr_w-1:0] r_p_cnt;
    logic [addr_w-1:0] r_n_q_m1;

    logic w_host_wr;
    logic w_last_write;

    assign w_host_wr    = host_wr_q | host_wr_k;
    assign w_last_write = (r_state == S_DRAIN) && fifo_valid && (r_p_cnt == r_n_q_m1);

    assign busy = (r_state != S_IDLE);
    assign done = w_last_write;

    // NOTE: state and counters use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_k_cnt  <= '0;
            r_q_cnt  <= '0;
            r_p_cnt  <= '0;
            r_n_q_m1 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n_q_m1 <= n_q_m1;
                        r_k_cnt  <= '0;
                        r_q_cnt  <= '0;
                        r_p_cnt  <= '0;
                        r_state  <= S_KLOAD;
                    end
                end
                S_KLOAD: begin
                    if (r_k_cnt == K_LAST) begin
                        r_state <= S_KFLUSH;
                    end else begin
                        r_k_cnt <= r_k_cnt + 1'b1;
                    end
                end
                S_KFLUSH: r_state <= S_EXEC;
                S_EXEC: begin
                    if (r_q_cnt == r_n_q_m1) begin
                        r_state <= S_EFLUSH;
                    end else begin
                        r_q_cnt <= r_q_cnt + 1'b1;
                    end
                end
                S_EFLUSH: r_state <= S_DRAIN;
                S_DRAIN: begin
                    if (w_last_write) begin
                        r_state <= S_IDLE;
                    end else if (fifo_valid) begin
                        r_p_cnt <= r_p_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: inst is cleared first so every path through the case assigns it
    // and no latch is inferred for the bits a state leaves untouched.
    always_comb begin
        inst = '0;
        case (r_state)
            S_IDLE: begin
                // An accepted start suppresses any host write in the same cycle.
                if (!start && w_host_wr) begin
                    inst[4]     = host_wr_q;
                    inst[2]     = host_wr_k;
                    inst[15:12] = host_addr;
                end
            end
            S_KLOAD: begin
                inst[6]     = 1'b1;
                inst[3]     = 1'b1;
                inst[15:12] = r_k_cnt;
            end
            S_KFLUSH: inst[6] = 1'b1;
            S_EXEC: begin
                inst[7]     = 1'b1;
                inst[5]     = 1'b1;
                inst[15:12] = r_q_cnt;
            end
            S_EFLUSH: inst[7] = 1'b1;
            S_DRAIN: begin
                inst[16]   = fifo_valid;
                inst[0]    = fifo_valid;
                inst[11:8] = r_p_cnt;
            end
            default: inst = '0;
        endcase
    end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed testbench for core_seq_ctrl: host pass-through, full passes,
// ignored inputs while busy, mid-pass reset and the maximum Q count.
module tb_core_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  n_q_m1;
    logic        host_wr_q;
    logic        host_wr_k;
    logic [3:0]  host_addr;
    logic        fifo_valid;
    logic [16:0] inst;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_err = 0;

    core_seq_ctrl #(.col(8), .addr_w(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .n_q_m1     (n_q_m1),
        .host_wr_q  (host_wr_q),
        .host_wr_k  (host_wr_k),
        .host_addr  (host_addr),
        .fifo_valid (fifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        start      = 1'b0;
        n_q_m1     = 4'd0;
        host_wr_q  = 1'b0;
        host_wr_k  = 1'b0;
        host_addr  = 4'd0;
        fifo_valid = 1'b0;
    endtask

    // Drives inputs that must be ignored while busy.
    task automatic drive_noise(input bit noise);
        start     = noise;
        n_q_m1    = noise ? 4'hA : 4'h0;
        host_wr_q = noise;
        host_wr_k = noise;
        host_addr = noise ? 4'hF : 4'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_chk++;
        if (inst !== 17'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset: inst=%h busy=%b done=%b expected inst=00000 busy=0 done=0", inst, busy, done);
        end
    endtask

    task automatic test_host_pass();
        @(negedge clk);
        host_wr_q = 1'b1; host_addr = 4'd5;
        #1;
        n_chk++;
        if (inst !== 17'h05010 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL host_wr_q: inst=%h busy=%b expected inst=05010 busy=0", inst, busy);
        end
        @(negedge clk);
        host_wr_q = 1'b0; host_wr_k = 1'b1; host_addr = 4'd3;
        #1;
        n_chk++;
        if (inst !== 17'h03004 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL host_wr_k: inst=%h busy=%b expected inst=03004 busy=0", inst, busy);
        end
        @(negedge clk);
        host_wr_k = 1'b0;
        #1;
        n_chk++;
        if (inst !== 17'h0) begin
            n_err++;
            $display("FAIL host_idle_addr_only: inst=%h expected 00000", inst);
        end
    endtask

    // One full pass; pattern[i] is fifo_valid on the i-th DRAIN cycle.
    task automatic do_pass(input logic [3:0] nq, input bit host_on_start, input bit noise,
                           input logic [31:0] pattern, input string tag);
        logic [16:0] exp;
        logic        exp_done;
        int          p;
        bit          fin;
        @(negedge clk);
        start = 1'b1; n_q_m1 = nq;
        host_wr_q = host_on_start; host_addr = host_on_start ? 4'd5 : 4'd0;
        #1;
        n_chk++;
        if (inst !== 17'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s start: inst=%h busy=%b done=%b expected inst=00000 busy=0 done=0", tag, inst, busy, done);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive_noise(noise);
            #1;
            exp = 17'h00048 | (17'(k) << 12);
            n_chk++;
            if (inst !== exp || busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL %s kload k=%0d: inst=%h busy=%b expected inst=%h busy=1", tag, k, inst, busy, exp);
            end
        end
        @(negedge clk);
        drive_noise(noise);
        #1;
        n_chk++;
        if (inst !== 17'h00040 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s kflush: inst=%h busy=%b expected inst=00040 busy=1", tag, inst, busy);
        end
        for (int q = 0; q <= int'(nq); q++) begin
            @(negedge clk);
            drive_noise(noise);
            #1;
            exp = 17'h000A0 | (17'(q) << 12);
            n_chk++;
            if (inst !== exp || busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL %s exec q=%0d: inst=%h busy=%b expected inst=%h busy=1", tag, q, inst, busy, exp);
            end
        end
        @(negedge clk);
        drive_noise(noise);
        #1;
        n_chk++;
        if (inst !== 17'h00080 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s eflush: inst=%h busy=%b expected inst=00080 busy=1", tag, inst, busy);
        end
        p   = 0;
        fin = 1'b0;
        for (int i = 0; i < 64 && !fin; i++) begin
            @(negedge clk);
            drive_noise(noise);
            fifo_valid = pattern[i % 32];
            #1;
            exp      = {fifo_valid, 4'b0, p[3:0], 7'b0, fifo_valid};
            exp_done = fifo_valid && (p == int'(nq));
            n_chk++;
            if (inst !== exp || done !== exp_done || busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s drain i=%0d: inst=%h done=%b busy=%b expected inst=%h done=%b busy=1",
                         tag, i, inst, done, busy, exp, exp_done);
            end
            if (fifo_valid) begin
                if (p == int'(nq)) fin = 1'b1;
                p++;
            end
        end
        if (!fin) begin
            n_chk++;
            n_err++;
            $display("FAIL %s drain_timeout: writes=%0d expected %0d", tag, p, int'(nq) + 1);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_chk++;
        if (inst !== 17'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s after_done: inst=%h busy=%b done=%b expected inst=00000 busy=0 done=0", tag, inst, busy, done);
        end
    endtask

    task automatic test_basic_pass();
        // fifo_valid sequence 1,0,1,1,1
        do_pass(4'd3, 1'b0, 1'b0, 32'h0000_001D, "basic");
    endtask

    task automatic test_start_with_host_and_noise();
        do_pass(4'd3, 1'b1, 1'b1, 32'h0000_001D, "noise");
    endtask

    task automatic test_reset_mid_pass();
        logic [16:0] exp;
        @(negedge clk);
        start = 1'b1; n_q_m1 = 4'd3;
        // 8 KLOAD + 1 KFLUSH + EXEC q=0,1
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        #1;
        exp = 17'h020A0;
        n_chk++;
        if (inst !== exp) begin
            n_err++;
            $display("FAIL midrst exec_q2: inst=%h expected %h", inst, exp);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_chk++;
        if (inst !== 17'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL midrst idle: inst=%h busy=%b done=%b expected inst=00000 busy=0 done=0", inst, busy, done);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            fifo_valid = 1'b1;
            #1;
            n_chk++;
            if (done !== 1'b0 || busy !== 1'b0 || inst !== 17'h0) begin
                n_err++;
                $display("FAIL midrst stays_idle c=%0d: inst=%h busy=%b done=%b expected 00000/0/0", c, inst, busy, done);
            end
        end
        fifo_valid = 1'b0;
        do_pass(4'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, "replay");
    endtask

    task automatic test_max_q();
        do_pass(4'd15, 1'b0, 1'b0, 32'hFFFF_FFFF, "maxq");
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_host_pass();
        test_basic_pass();
        test_start_with_host_and_noise();
        test_reset_mid_pass();
        test_max_q();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
Instruction sequencer for the attention core. It drives the core's 17-bit inst bus to run one full pass: preload kernel rows from kmem into the MAC array, stream Q vectors from qmem through the array, then drain the output FIFO into psum memory. In IDLE, host Q/K memory writes pass through to the core; during a pass they are blocked. The block sits between the testbench/host and the core's inst input, and observes the core's ofifo o_valid.

Parameters:
col, 8, MAC array columns = number of kernel rows loaded per pass (1..16)
addr_w, 4, qk/psum address width; fixed by inst field widths

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a pass when sampled in IDLE
n_q_m1  input  4  number of Q vectors minus one (1..16); captured on accepted start
host_wr_q  input  1  host qmem write request (IDLE only)
host_wr_k  input  1  host kmem write request (IDLE only)
host_addr  input  4  host write address
fifo_valid  input  1  core ofifo o_valid
inst  output  17  core instruction: [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] kernel load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on pass completion

Behaviour:
- One clock; reset is synchronous and active-high. On reset: state=IDLE, all counters=0, busy=0, done=0. inst=0 whenever host write inputs are low.
- inst is decoded from registered state/counters. inst[16] and inst[0] additionally depend combinationally on fifo_valid (DRAIN only). No other input feeds inst except the host pass-through in IDLE.
- States: IDLE -> KLOAD -> KFLUSH -> EXEC -> EFLUSH -> DRAIN -> IDLE.
- IDLE: inst[4]=host_wr_q, inst[2]=host_wr_k, inst[15:12]=host_addr, other bits 0.
  - start=1: capture n_q_m1, clear counters, go to KLOAD next cycle. Host writes in that same cycle are suppressed (inst=0).
- KLOAD: col cycles, k_cnt 0..col-1. inst[6]=1, inst[3]=1, qkmem_add=k_cnt. After k_cnt==col-1 -> KFLUSH.
- KFLUSH: 1 cycle. inst[6]=1, kmem_rd=0, covering the 1-cycle SRAM read latency. -> EXEC.
- EXEC: n_q_m1+1 cycles, q_cnt 0..n_q_m1. inst[7]=1, inst[5]=1, qkmem_add=q_cnt. After last -> EFLUSH.
- EFLUSH: 1 cycle. inst[7]=1, qmem_rd=0. -> DRAIN.
- DRAIN: inst[16]=inst[0]=fifo_valid, pmem_add=p_cnt.
  - Each cycle with fifo_valid=1: one FIFO word is read and written to psum address p_cnt, then p_cnt increments.
  - When the write with p_cnt==n_q_m1 occurs: go to IDLE, pulse done that same cycle.
  - fifo_valid low: wait indefinitely, emitting no read/write.
- start, host_wr_q, host_wr_k while busy: ignored, with no effect on inst or state.
- All counters are 4 bits. p_cnt never wraps because n_q_m1≤15 terminates the pass first.
- Reset mid-pass: returns to IDLE on the next edge and drops all in-flight sequencing. No done pulse. The core state is not cleaned up; the host must reset the core as well.
- inst[1] (pmem_rd) is never driven by this block; it is always 0.

Test Plan:
- Reset then idle with host_wr_q=1, host_addr=5 -> inst=0x05010 (bit4 set, addr 5); busy=0. With host_wr_k=1, host_addr=3 -> inst=0x03004.
- start with n_q_m1=3, col=8 -> KLOAD emits 8 cycles of inst[6]=inst[3]=1 with addr 0..7, then 1 KFLUSH cycle with inst=0x00040. EXEC emits 4 cycles of inst[7]=inst[5]=1 with addr 0..3, then EFLUSH inst=0x00080.
- DRAIN with fifo_valid pattern 1,0,1,1,1 -> pmem_wr/ofifo_rd asserted on the four valid cycles only, pmem_add 0,1,2,3. done pulses on the 4th write; busy falls the next cycle.
- start in the same cycle as host_wr_q=1 -> inst=0 that cycle, pass begins. start/host writes during EXEC -> no change to sequence.
- Assert reset during EXEC (q_cnt=2) -> next cycle IDLE, inst=0, busy=0, done never pulses. A fresh start then replays from k_cnt=0.
- n_q_m1=15 -> 16 EXEC cycles with addr 0..15, 16 drain writes with pmem_add 0..15, no wrap, a single done pulse.
